// File: rtl/backward_arbiter_wrr_if.sv
// Return-path arbiter bundle: slave FIFO heads and master FIFO status in, grant/push/pop out.
// The master modport is the arbiter side; the slave modport is the crossbar/FIFO side.
interface backward_arbiter_wrr_if #(
  parameter int MASTERS  = 2,
  parameter int SLAVES   = 2,
  parameter int WEIGHT_W = 4
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  logic [SLAVES-1:0]               slave_fifo_empty;
  logic [SLAVES-1:0][MW-1:0]       slave_master_dest;
  logic [SLAVES-1:0]               slave_last;
  logic [SLAVES-1:0][WEIGHT_W-1:0] slave_weight;
  logic                            master_fifo_full;
  logic                            push_to_fifo;
  logic [SLAVES-1:0]               pop_slave;
  logic                            grant_valid;
  logic [SW-1:0]                   grant_slave_number;
  logic                            locked;

  modport master (
    input  slave_fifo_empty, slave_master_dest, slave_last, slave_weight, master_fifo_full,
    output push_to_fifo, pop_slave, grant_valid, grant_slave_number, locked
  );

  modport slave (
    output slave_fifo_empty, slave_master_dest, slave_last, slave_weight, master_fifo_full,
    input  push_to_fifo, pop_slave, grant_valid, grant_slave_number, locked
  );
endinterface

// File: rtl/backward_arbiter_wrr.sv
// Weighted round-robin return arbiter with burst lock; grant is combinational (0 cycles),
// master_fifo_full stalls push/pop and freezes all arbitration state.
module backward_arbiter_wrr #(
  parameter int MASTERS   = 2,
  parameter int SLAVES    = 2,
  parameter int MASTER_ID = 0,
  parameter int WEIGHT_W  = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  backward_arbiter_wrr_if.master bus
);
  localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       ptr_q, ptr_d, lock_q, lock_d;
  logic [WEIGHT_W-1:0] cred_q, cred_d;
  logic [SLAVES-1:0]   req, pop;
  logic                cand_vld, gnt_vld, push, done;
  logic [SW-1:0]       cand, gnt;
  logic [WEIGHT_W:0]   eff_w;

  always_comb begin
    for (int i = 0; i < SLAVES; i++)
      req[i] = ~bus.slave_fifo_empty[i] & (bus.slave_master_dest[i] == MW'(MASTER_ID));
  end

  // Scan from the highest offset down so the offset closest to ptr wins.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      if (req[(int'(ptr_q) + k) % SLAVES]) begin
        cand_vld = 1'b1;
        cand     = SW'((int'(ptr_q) + k) % SLAVES);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      cred_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cred_q  <= cred_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    cred_d  = cred_q;
    eff_w   = (bus.slave_weight[gnt] == '0) ? (WEIGHT_W+1)'(1) : {1'b0, bus.slave_weight[gnt]};
    if (push && state_q == IDLE && !bus.slave_last[gnt]) begin
      state_d = LOCKED;
      lock_d  = gnt;
    end
    if (done) begin
      state_d = IDLE;
      if (gnt == ptr_q && ({1'b0, cred_q} + (WEIGHT_W+1)'(1)) < eff_w) begin
        cred_d = cred_q + WEIGHT_W'(1);
      end else begin
        ptr_d  = (int'(gnt) == SLAVES - 1) ? '0 : gnt + SW'(1);
        cred_d = '0;
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    if (!ARESET) begin
      if (state_q == IDLE) begin
        gnt_vld = cand_vld;
        gnt     = cand_vld ? cand : '0;
      end else begin
        gnt_vld = req[lock_q];
        gnt     = req[lock_q] ? lock_q : '0;
      end
    end
    push = gnt_vld & ~bus.master_fifo_full;
    done = push & bus.slave_last[gnt];
    for (int i = 0; i < SLAVES; i++)
      pop[i] = push && (gnt == SW'(i));
  end

  assign bus.grant_valid        = gnt_vld;
  assign bus.grant_slave_number = gnt;
  assign bus.push_to_fifo       = push;
  assign bus.pop_slave          = pop;
  assign bus.locked             = (state_q == LOCKED) & ~ARESET;
endmodule

// File: tb/tb_backward_arbiter_wrr.sv
// Scoreboard bench: a 4-slave instance for RR/lock/stall/filter/reset, a 2-slave one for WRR.
module tb_backward_arbiter_wrr;
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  backward_arbiter_wrr_if #(.MASTERS(2), .SLAVES(4), .WEIGHT_W(4)) bus1 ();
  backward_arbiter_wrr_if #(.MASTERS(2), .SLAVES(2), .WEIGHT_W(4)) bus2 ();

  backward_arbiter_wrr #(.MASTERS(2), .SLAVES(4), .MASTER_ID(0), .WEIGHT_W(4)) u_dut1 (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus1));
  backward_arbiter_wrr #(.MASTERS(2), .SLAVES(2), .MASTER_ID(0), .WEIGHT_W(4)) u_dut2 (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus2));

  typedef struct {
    bit       sel;
    int       step;
    logic       vld;
    logic [1:0] gnt;
    logic       push;
    logic [3:0] pop;
    logic       lk;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;
  logic [3:0] dest_v = 4'b0000;

  task automatic chk(input string name, input int st, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, st, got, want);
    end
  endtask

  // Outputs are sampled mid-cycle, after the inputs driven at posedge+1 have settled.
  always @(negedge ACLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (!e.sel) begin
        chk("grant_valid", e.step, {3'b0, bus1.grant_valid}, {3'b0, e.vld});
        chk("grant_slave_number", e.step, {2'b0, bus1.grant_slave_number}, {2'b0, e.gnt});
        chk("push_to_fifo", e.step, {3'b0, bus1.push_to_fifo}, {3'b0, e.push});
        chk("pop_slave", e.step, bus1.pop_slave, e.pop);
        chk("locked", e.step, {3'b0, bus1.locked}, {3'b0, e.lk});
      end else begin
        chk("grant_valid2", e.step, {3'b0, bus2.grant_valid}, {3'b0, e.vld});
        chk("grant_slave_number2", e.step, {3'b0, bus2.grant_slave_number}, {2'b0, e.gnt});
        chk("push_to_fifo2", e.step, {3'b0, bus2.push_to_fifo}, {3'b0, e.push});
        chk("pop_slave2", e.step, {2'b0, bus2.pop_slave}, e.pop);
        chk("locked2", e.step, {3'b0, bus2.locked}, {3'b0, e.lk});
      end
    end
  end

  task automatic cyc(input logic rst, input logic [3:0] ne, input logic [3:0] lst, input logic full,
                     input bit sel, input logic ev, input logic [1:0] eg, input logic ep, input logic el);
    exp_t e;
    @(posedge ACLK);
    #1;
    ARESET = rst;
    bus1.slave_fifo_empty = ~ne;
    bus1.slave_last       = lst;
    bus1.master_fifo_full = full;
    bus2.slave_fifo_empty = ~ne[1:0];
    bus2.slave_last       = lst[1:0];
    bus2.master_fifo_full = full;
    for (int i = 0; i < 4; i++) bus1.slave_master_dest[i] = dest_v[i];
    for (int i = 0; i < 2; i++) bus2.slave_master_dest[i] = dest_v[i];
    e.sel  = sel;
    e.step = step;
    e.vld  = ev;
    e.gnt  = eg;
    e.push = ep;
    e.pop  = ep ? (4'b0001 << eg) : 4'b0000;
    e.lk   = el;
    q.push_back(e);
    step++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    ARESET = 1'b1;
    bus1.slave_fifo_empty = '1;
    bus1.slave_master_dest = '0;
    bus1.slave_last = '0;
    bus1.master_fifo_full = 1'b0;
    bus1.slave_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    bus2.slave_fifo_empty = '1;
    bus2.slave_master_dest = '0;
    bus2.slave_last = '0;
    bus2.master_fifo_full = 1'b0;
    bus2.slave_weight = {4'd1, 4'd3};

    // reset with every FIFO requesting this master
    cyc(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0);

    // plain round robin, single-beat packets, wraps 3 -> 0
    cyc(0, 4'b1111, 4'b1111, 0, 0, 1, 0, 1, 0);
    cyc(0, 4'b1111, 4'b1111, 0, 0, 1, 1, 1, 0);
    cyc(0, 4'b1111, 4'b1111, 0, 0, 1, 2, 1, 0);
    cyc(0, 4'b1111, 4'b1111, 0, 0, 1, 3, 1, 0);
    cyc(0, 4'b1111, 4'b1111, 0, 0, 1, 0, 1, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 0, 0, 0, 0, 0);

    // weighted: slave 0 weight 3, slave 1 weight 1 (2-slave instance)
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 0, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 0, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 0, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 1, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 0, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 0, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 0, 1, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 1, 1, 1, 1, 0);
    cyc(1, 4'b0011, 4'b0011, 0, 0, 0, 0, 0, 0);

    // 4-beat burst from slave 1; slave 0 joins on beat 2 and waits
    cyc(0, 4'b0010, 4'b0000, 0, 0, 1, 1, 1, 0);
    cyc(0, 4'b0011, 4'b0000, 0, 0, 1, 1, 1, 1);
    cyc(0, 4'b0011, 4'b0000, 0, 0, 1, 1, 1, 1);
    cyc(0, 4'b0011, 4'b0010, 0, 0, 1, 1, 1, 1);
    cyc(0, 4'b0001, 4'b0001, 0, 0, 1, 0, 1, 0);

    // stall mid-burst: master full 3 cycles, then locked FIFO empty 2 cycles
    cyc(0, 4'b0011, 4'b0000, 0, 0, 1, 1, 1, 0);
    cyc(0, 4'b0011, 4'b0000, 1, 0, 1, 1, 0, 1);
    cyc(0, 4'b0011, 4'b0000, 1, 0, 1, 1, 0, 1);
    cyc(0, 4'b0011, 4'b0000, 1, 0, 1, 1, 0, 1);
    cyc(0, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 1);
    cyc(0, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 1);
    cyc(0, 4'b0011, 4'b0010, 0, 0, 1, 1, 1, 1);
    cyc(0, 4'b0011, 4'b0011, 0, 0, 1, 0, 1, 0);

    // slave 2 head routed to the other master is never granted
    dest_v = 4'b0100;
    cyc(0, 4'b0111, 4'b0111, 0, 0, 1, 1, 1, 0);
    cyc(0, 4'b0111, 4'b0111, 0, 0, 1, 0, 1, 0);
    cyc(0, 4'b0111, 4'b0111, 0, 0, 1, 1, 1, 0);
    cyc(0, 4'b0111, 4'b0111, 0, 0, 1, 0, 1, 0);

    // reset during a lock: lock dropped, pointer back at 0
    cyc(0, 4'b0011, 4'b0000, 0, 0, 1, 1, 1, 0);
    cyc(1, 4'b0011, 4'b0000, 0, 0, 0, 0, 0, 0);
    cyc(0, 4'b0011, 4'b0011, 0, 0, 1, 0, 1, 0);

    for (int n = 0; n < 20 && q.size() > 0; n++) @(posedge ACLK);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
